// File: rtl/bcd_seq_ctrl.sv
// Load/run sequencer for an external BCD counter: arbitrates two preset requesters,
// prescales count enables and flags 9->0 wraps. Define BCD_SEQ_CTRL_ROUNDROBIN_EN for round-robin arbitration.
module bcd_seq_ctrl #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic       clk,
    input  logic       rst_syn,
    input  logic [1:0] req,
    input  logic [3:0] req_num0,
    input  logic [3:0] req_num1,
    input  logic       run,
    input  logic [3:0] q_in,
    output logic [1:0] gnt,
    output logic       load,
    output logic [3:0] load_num,
    output logic       cnt_en,
    output logic       carry,
    output logic       err,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        LOAD      = 2'b01,
        RUN       = 2'b10,
        ST_UNUSED = 2'b11
    } state_t;

    state_t     state_reg, state_next;
    logic [3:0] psc_reg, psc_next;
    logic [1:0] gnt_reg, gnt_next;
    logic       load_reg, load_next;
    logic [3:0] load_num_reg, load_num_next;
    logic       cnt_en_reg, cnt_en_next;
    logic       carry_reg, carry_next;
    logic       err_reg, err_next;

    logic       win1;
    logic [3:0] win_num;
    logic [1:0] win_gnt;

`ifdef BCD_SEQ_CTRL_ROUNDROBIN_EN
    // ptr_reg set means requester 1 is favoured on a tie (requester 0 was granted last).
    logic ptr_reg;

    always_ff @(posedge clk or negedge rst_syn) begin
        if (!rst_syn) begin
            ptr_reg <= 1'b0;
        end else if (|gnt_next) begin
            ptr_reg <= gnt_next[0];
        end
    end

    assign win1 = req[1] & (~req[0] | ptr_reg);
`else
    assign win1 = req[1] & ~req[0];
`endif

    assign win_num = win1 ? req_num1 : req_num0;
    assign win_gnt = win1 ? 2'b10 : 2'b01;

    always_comb begin
        state_next    = state_reg;
        psc_next      = psc_reg;
        gnt_next      = 2'b00;
        load_next     = 1'b0;
        load_num_next = load_num_reg;
        cnt_en_next   = 1'b0;
        carry_next    = 1'b0;
        err_next      = 1'b0;

        case (state_reg)
            IDLE, RUN: begin
                if (|req) begin
                    // Grant is registered so it lines up with the LOAD cycle.
                    state_next    = LOAD;
                    psc_next      = 4'd0;
                    gnt_next      = win_gnt;
                    load_num_next = win_num;
                    load_next     = (win_num <= 4'd9);
                    err_next      = (win_num > 4'd9);
                end else if (state_reg == IDLE) begin
                    psc_next = 4'd0;
                    if (run) begin
                        state_next = RUN;
                    end
                end else if (!run) begin
                    state_next = IDLE;
                    psc_next   = 4'd0;
                end else if (psc_reg == 4'(PRESCALE - 1)) begin
                    psc_next    = 4'd0;
                    cnt_en_next = 1'b1;
                    carry_next  = (q_in == 4'd9);
                end else begin
                    psc_next = psc_reg + 4'd1;
                end
            end
            LOAD: begin
                psc_next   = 4'd0;
                state_next = run ? RUN : IDLE;
            end
            default: begin
                state_next = IDLE;
                psc_next   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_syn) begin
        if (!rst_syn) begin
            state_reg    <= IDLE;
            psc_reg      <= 4'd0;
            gnt_reg      <= 2'b00;
            load_reg     <= 1'b0;
            load_num_reg <= 4'd0;
            cnt_en_reg   <= 1'b0;
            carry_reg    <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            psc_reg      <= psc_next;
            gnt_reg      <= gnt_next;
            load_reg     <= load_next;
            load_num_reg <= load_num_next;
            cnt_en_reg   <= cnt_en_next;
            carry_reg    <= carry_next;
            err_reg      <= err_next;
        end
    end

    assign state    = state_reg;
    assign gnt      = gnt_reg;
    assign load     = load_reg;
    assign load_num = load_num_reg;
    assign cnt_en   = cnt_en_reg;
    assign carry    = carry_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// Directed bench for bcd_seq_ctrl: grant/load results go through a scoreboard queue,
// state/cnt_en/carry are checked every sampled cycle.
module tb_bcd_seq_ctrl;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_LOAD = 2'b01;
    localparam logic [1:0] S_RUN  = 2'b10;

    logic       clk = 1'b0;
    logic       rst_syn;
    logic [1:0] req;
    logic [3:0] req_num0;
    logic [3:0] req_num1;
    logic       run;
    logic [3:0] q_in;
    logic [1:0] gnt;
    logic       load;
    logic [3:0] load_num;
    logic       cnt_en;
    logic       carry;
    logic       err;
    logic [1:0] state;

    typedef struct packed {
        logic [1:0] gnt;
        logic       load;
        logic [3:0] num;
        logic       err;
    } exp_t;

    exp_t       sb_q[$];
    logic [3:0] last_num;
    int         total = 0;
    int         bad = 0;

    bcd_seq_ctrl #(.PRESCALE(4)) dut (
        .clk      (clk),
        .rst_syn  (rst_syn),
        .req      (req),
        .req_num0 (req_num0),
        .req_num1 (req_num1),
        .run      (run),
        .q_in     (q_in),
        .gnt      (gnt),
        .load     (load),
        .load_num (load_num),
        .cnt_en   (cnt_en),
        .carry    (carry),
        .err      (err),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] g, input logic l, input logic [3:0] n, input logic e);
        exp_t x;
        x.gnt  = g;
        x.load = l;
        x.num  = n;
        x.err  = e;
        sb_q.push_back(x);
    endtask

    // One sampled cycle: fixed expectations for state/cnt_en/carry, scoreboard for LOAD results.
    task automatic cyc(input string tag, input logic [1:0] es, input logic ec, input logic ecar);
        exp_t e;
        chk({tag, ".state"}, 8'(state), 8'(es));
        chk({tag, ".cnt_en"}, 8'(cnt_en), 8'(ec));
        chk({tag, ".carry"}, 8'(carry), 8'(ecar));
        if (es == S_LOAD) begin
            total++;
            assert (sb_q.size() != 0) else begin
                bad++;
                $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
            end
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                last_num = e.num;
                chk({tag, ".gnt"}, 8'(gnt), 8'(e.gnt));
                chk({tag, ".load"}, 8'(load), 8'(e.load));
                chk({tag, ".err"}, 8'(err), 8'(e.err));
            end
        end else begin
            chk({tag, ".gnt"}, 8'(gnt), 8'h00);
            chk({tag, ".load"}, 8'(load), 8'h00);
            chk({tag, ".err"}, 8'(err), 8'h00);
        end
        chk({tag, ".load_num"}, 8'(load_num), 8'(last_num));
        $display("%0t %s state=%b gnt=%b load=%b num=%0h cnt_en=%b carry=%b err=%b",
                 $time, tag, state, gnt, load, load_num, cnt_en, carry, err);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".state"}, 8'(state), 8'h00);
        chk({tag, ".gnt"}, 8'(gnt), 8'h00);
        chk({tag, ".load"}, 8'(load), 8'h00);
        chk({tag, ".load_num"}, 8'(load_num), 8'h00);
        chk({tag, ".cnt_en"}, 8'(cnt_en), 8'h00);
        chk({tag, ".carry"}, 8'(carry), 8'h00);
        chk({tag, ".err"}, 8'(err), 8'h00);
        $display("%0t %s async reset state=%b load_num=%0h", $time, tag, state, load_num);
    endtask

    initial begin
        logic en_e;
        rst_syn  = 1'b1;
        req      = 2'b00;
        req_num0 = 4'd0;
        req_num1 = 4'd0;
        run      = 1'b0;
        q_in     = 4'd0;
        last_num = 4'd0;

        // Reset asserted before the first clock edge must take effect at once.
        #2 rst_syn = 1'b0;
        #1 chk_all_zero("reset_init");
        tick();
        tick();
        @(negedge clk) rst_syn = 1'b1;

        // Single load from requester 1, evaluated on the first edge after release.
        req = 2'b10; req_num1 = 4'd7;
        push(2'b10, 1'b1, 4'd7, 1'b0);
        tick(); cyc("load1", S_LOAD, 1'b0, 1'b0);
        req = 2'b00;
        tick(); cyc("load1_after", S_IDLE, 1'b0, 1'b0);

        // Non-BCD preset: grant still retires the request, no load, err pulses.
        req = 2'b01; req_num0 = 4'hC;
        push(2'b01, 1'b0, 4'hC, 1'b1);
        tick(); cyc("badval", S_LOAD, 1'b0, 1'b0);
        req = 2'b00;
        tick(); cyc("badval_after", S_IDLE, 1'b0, 1'b0);

        // Counting: cnt_en every 4th cycle, carry only where q_in was 9 at that edge.
        run = 1'b1; q_in = 4'd9;
        for (int c = 0; c < 14; c++) begin
            tick();
            en_e = (c > 0) && (c % 4 == 0);
            cyc($sformatf("count_c%0d", c), S_RUN, en_e, en_e && (q_in == 4'd9));
            q_in = (((c / 4) % 2) == 0) ? 4'd9 : 4'd5;
        end

        // Reset in the middle of a prescale period.
        #2 rst_syn = 1'b0;
        #1 chk_all_zero("reset_run");
        last_num = 4'd0;
        tick(); cyc("reset_hold0", S_IDLE, 1'b0, 1'b0);
        tick(); cyc("reset_hold1", S_IDLE, 1'b0, 1'b0);
        @(negedge clk) begin rst_syn = 1'b1; run = 1'b0; end
        tick(); cyc("reset_rel0", S_IDLE, 1'b0, 1'b0);
        tick(); cyc("reset_rel1", S_IDLE, 1'b0, 1'b0);

        // Arbitration with both requesters held.
        req = 2'b11; req_num0 = 4'd2; req_num1 = 4'd5;
        push(2'b01, 1'b1, 4'd2, 1'b0);
        tick(); cyc("arb_g1", S_LOAD, 1'b0, 1'b0);
`ifdef BCD_SEQ_CTRL_ROUNDROBIN_EN
        push(2'b10, 1'b1, 4'd5, 1'b0);
`else
        push(2'b01, 1'b1, 4'd2, 1'b0);
`endif
        tick(); cyc("arb_gap1", S_IDLE, 1'b0, 1'b0);
        tick(); cyc("arb_g2", S_LOAD, 1'b0, 1'b0);
`ifndef BCD_SEQ_CTRL_ROUNDROBIN_EN
        req = 2'b10;
        push(2'b10, 1'b1, 4'd5, 1'b0);
        tick(); cyc("arb_gap2", S_IDLE, 1'b0, 1'b0);
        tick(); cyc("arb_g3", S_LOAD, 1'b0, 1'b0);
`endif
        req = 2'b00;
        tick(); cyc("arb_done", S_IDLE, 1'b0, 1'b0);

        // Preemption: request during RUN, then prescale restarts from zero.
        run = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            cyc($sformatf("pre_c%0d", c), S_RUN, (c == 4), 1'b0);
        end
        req = 2'b01; req_num0 = 4'd3;
        push(2'b01, 1'b1, 4'd3, 1'b0);
        tick(); cyc("pre_load", S_LOAD, 1'b0, 1'b0);
        req = 2'b00;
        for (int r = 0; r < 6; r++) begin
            tick();
            cyc($sformatf("pre_r%0d", r), S_RUN, (r == 4), 1'b0);
        end
        run = 1'b0;
        tick(); cyc("pre_idle", S_IDLE, 1'b0, 1'b0);

        chk("sb_empty", 8'(sb_q.size()), 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_seq_ctrl.md
BCD_SEQ_CTRL -- requirements
Module: bcd_seq_ctrl

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 4, giving clock cycles per count-enable pulse in RUN; legal range 2..15.
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port rst_syn, input, 1, the asynchronous active-low reset.
REQ-004 The block SHALL have port req, input, 2, load requests from requester 0 and requester 1, each held high until granted.
REQ-005 The block SHALL have ports req_num0 and req_num1, input, 4 each, the BCD preset value of each requester.
REQ-006 The block SHALL have port run, input, 1, a level that enables counting.
REQ-007 The block SHALL have port q_in, input, 4, the current BCD digit fed back from the counter.
REQ-008 The block SHALL have port gnt, output, 2, a one-hot one-cycle grant pulse.
REQ-009 The block SHALL have port load, output, 1, the load strobe to the counter.
REQ-010 The block SHALL have port load_num, output, 4, the preset value to the counter.
REQ-011 The block SHALL have port cnt_en, output, 1, the count-enable pulse to the counter.
REQ-012 The block SHALL have port carry, output, 1, a one-cycle pulse marking a 9-to-0 wrap.
REQ-013 The block SHALL have port err, output, 1, a one-cycle pulse for a non-BCD request value.
REQ-014 The block SHALL have port state, output, 2, the current FSM state.

Function
REQ-015 The FSM SHALL have states IDLE=2'b00, LOAD=2'b01, RUN=2'b10; encoding 2'b11 is unused and SHALL return to IDLE on the next clock.
REQ-016 From IDLE or RUN, any req bit high SHALL move the FSM to LOAD on the next clock; req takes precedence over run.
REQ-017 From IDLE with req==0 and run==1, the FSM SHALL move to RUN; with both low it SHALL stay in IDLE.
REQ-018 LOAD SHALL last exactly one cycle, then go to RUN if run==1, else to IDLE.
REQ-019 In RUN with req==0 and run==0, the FSM SHALL go to IDLE on the next clock.
REQ-020 All outputs SHALL be registered; the values for request N SHALL appear in the cycle in which state==LOAD, one cycle after req is sampled.
REQ-021 In the LOAD cycle, gnt SHALL be one-hot for the winning requester, and load_num SHALL equal that requester's req_num.
REQ-022 In the LOAD cycle, load SHALL be 1 if load_num<=9.
REQ-023 If the winning value is greater than 9, load SHALL be 0, err SHALL be 1, and gnt SHALL still pulse to retire the request.
REQ-024 A 4-bit prescale counter SHALL run only in RUN and SHALL clear to 0 on entering RUN or LOAD.
REQ-025 cnt_en SHALL pulse for one cycle when the prescale counter reaches PRESCALE-1, and the counter SHALL then wrap to 0.
REQ-026 The first cnt_en after entering RUN SHALL occur PRESCALE cycles later.
REQ-027 carry SHALL pulse in the same cycle as cnt_en when q_in==9 at that time; carry SHALL be 0 otherwise.
REQ-028 gnt, load, cnt_en, carry and err SHALL be 0 outside the cycles defined above.
REQ-029 load_num SHALL hold its last value between loads.
REQ-030 load and cnt_en SHALL never be 1 in the same cycle.

Reset
REQ-031 While rst_syn==0, the block SHALL immediately, independent of clk, force state=IDLE, gnt=0, load=0, load_num=0, cnt_en=0, carry=0, err=0, prescale counter=0 and round-robin pointer=0.
REQ-032 A reset asserted during LOAD or RUN SHALL abort that operation with no grant, load or cnt_en issued afterwards; pending req bits SHALL be re-arbitrated after release.
REQ-033 The first clock edge after rst_syn rises SHALL evaluate the IDLE transitions normally.

Configuration
REQ-034 Macro BCD_SEQ_CTRL_ROUNDROBIN_EN SHALL select the arbitration scheme.
REQ-035 With BCD_SEQ_CTRL_ROUNDROBIN_EN defined, on simultaneous requests the requester not granted most recently SHALL win; the pointer SHALL favour requester 0 after reset and update only on a grant.
REQ-036 Without BCD_SEQ_CTRL_ROUNDROBIN_EN, requester 0 SHALL always win, and no pointer register SHALL exist.

Verification
REQ-037 The bench SHALL check reset in RUN: with run=1 and PRESCALE=4, pulling rst_syn low mid-count -> all outputs 0 and state=00 before the next clk edge; no cnt_en until RUN is re-entered.
REQ-038 The bench SHALL check a single load: req=2'b10 with req_num1=7 in IDLE for one cycle -> next cycle state=01, gnt=2'b10, load=1, load_num=7; then state=00 with load_num still 7.
REQ-039 The bench SHALL check counting: run=1 and PRESCALE=4 -> cnt_en every 4th cycle; with q_in=9 at a cnt_en -> carry=1 in that cycle only.
REQ-040 The bench SHALL check arbitration: req=2'b11 held through two grants -> with the macro, gnt=01 then 10; without the macro, gnt=01 and requester 1 waits until req[0] drops.
REQ-041 The bench SHALL check a bad value: req=2'b01 with req_num0=4'hC -> in LOAD, gnt=01, err=1, load=0.
REQ-042 The bench SHALL check preemption: req arriving in RUN -> LOAD for one cycle, back to RUN, and the next cnt_en exactly 4 cycles after returning to RUN.
